cond_flag_unit: RTL and testbench
=================================

Name: cond_flag_unit

Overview:
- Conditional-execution stage directly downstream of the ALU in the single-cycle core.
- Holds the architectural NZCV flag register and updates it from the ALU flag outputs (Negative, Zero, Carry, Overflow).
- Evaluates the 4-bit instruction condition field against the current registered flags.
- Gates the decoder's PC/register/memory write strobes so that a failed-condition instruction has no architectural effect.

Parameters:
- FLAG_RESET, 4'b0000: NZCV value loaded on reset, ordered {N,Z,C,V}.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  instruction-valid / not-stalled qualifier.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {Negative,Zero,Carry,Overflow} from ALU, current instruction.
- FlagW  input  2  flag-write request from decoder; [1] = N,Z group, [0] = C,V group.
- PCS  input  1  decoder: instruction writes PC.
- RegW  input  1  decoder: instruction writes register file.
- MemW  input  1  decoder: instruction writes data memory.
- NoWrite  input  1  decoder: compare-type op, suppress register write.
- PCSrc  output  1  gated PC-write select.
- RegWrite  output  1  gated register-file write enable.
- MemWrite  output  1  gated data-memory write enable.
- CondEx  output  1  condition passed for current instruction.
- Flags  output  4  registered NZCV, {N,Z,C,V}.

Behaviour:
- Reset
  - rst sampled at posedge: Flags <= FLAG_RESET. FlagW and en are ignored that cycle.
  - While rst=1, PCSrc, RegWrite and MemWrite are forced 0 (combinational).
  - CondEx still reflects Cond against Flags while rst=1.
  - Reset mid-instruction discards any pending flag update; no partial group write.
- Condition evaluation
  - Combinational, zero latency.
  - Uses registered Flags only, never ALUFlags. An instruction sees the flags produced by earlier instructions, not its own.
  - Cond decode:
    - 0 EQ: Z
    - 1 NE: !Z
    - 2 CS: C
    - 3 CC: !C
    - 4 MI: N
    - 5 PL: !N
    - 6 VS: V
    - 7 VC: !V
    - 8 HI: C & !Z
    - 9 LS: !C | Z
    - A GE: N==V
    - B LT: N!=V
    - C GT: !Z & (N==V)
    - D LE: Z | (N!=V)
    - E AL: 1
    - F: 1 (treated as unconditional)
- Strobe gating, combinational
  - PCSrc = PCS & CondEx & en & !rst
  - RegWrite = RegW & CondEx & en & !NoWrite & !rst
  - MemWrite = MemW & CondEx & en & !rst
- Flag register update, at posedge when rst=0
  - If en & CondEx & FlagW[1]: {N,Z} <= ALUFlags[3:2].
  - If en & CondEx & FlagW[0]: {C,V} <= ALUFlags[1:0].
  - The two groups update independently. FlagW=2'b10 (logical ops) must leave C,V unchanged.
  - Otherwise Flags hold.
- Simultaneous events
  - A flag-setting instruction whose condition fails does not update flags.
  - A flag update and a condition read in the same cycle: the read sees the old value; the new value is visible from the next cycle.
  - en=0: Flags hold and all strobes are 0, regardless of FlagW, PCS, RegW or MemW.
- No internal FSM beyond the 4-bit flag state. Latency from ALU flags to usable condition is 1 cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with FlagW=2'b11, ALUFlags=4'b1111, en=1 -> Flags=4'b0000, RegWrite=0 throughout. After release, Cond=E with RegW=1 -> RegWrite=1.
- SUBS equal then BEQ: cycle0 Cond=E, FlagW=11, ALUFlags=4'b0110 -> Flags=4'b0110 next cycle. Cycle1 Cond=0, PCS=1 -> CondEx=1, PCSrc=1. Cond=1 with PCS=1 -> PCSrc=0.
- Partial update: Flags=4'b0011, then Cond=E, FlagW=10, ALUFlags=4'b1000 -> Flags=4'b1011 (C,V kept).
- Failed condition: Flags=4'b0000, Cond=0, FlagW=11, RegW=1, MemW=1, ALUFlags=4'b0100 -> CondEx=0, RegWrite=0, MemWrite=0, Flags stay 4'b0000.
- Signed compares: Flags N=1,V=0 -> GE (A) fails, LT (B) passes, LE (D) passes, GT (C) fails. Flags N=1,V=1,Z=0 -> GE and GT pass. NoWrite=1 with RegW=1, Cond=E -> RegWrite=0.
- Stall: en=0, Cond=E, FlagW=11, ALUFlags=4'b1111, PCS=RegW=MemW=1 -> all strobes 0, Flags unchanged. en=1 the next cycle -> update applied.

Source files
------------

// File: rtl/cond_flag_unit_if.sv
// Bundle of the decoder/ALU-facing signals of the conditional-execution
// stage. The stage itself is the slave; whoever drives instruction
// fields (decoder, or a testbench) is the master. A monitor view is
// provided for passive observers such as scoreboards or trace logic.
interface cond_flag_unit_if;

    // Instruction qualifier: the current instruction is real and the
    // pipeline is not stalled.
    logic       en;

    // Condition field of the instruction, Instr[31:28].
    logic [3:0] Cond;

    // {Negative, Zero, Carry, Overflow} produced by the ALU for the
    // instruction currently in this stage.
    logic [3:0] ALUFlags;

    // Flag-write request: [1] selects the N,Z group, [0] the C,V group.
    logic [1:0] FlagW;

    // Ungated write strobes from the decoder.
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;

    // Gated strobes and status returned by the stage.
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    // Instruction source side.
    modport master (
        output en,
        output Cond,
        output ALUFlags,
        output FlagW,
        output PCS,
        output RegW,
        output MemW,
        output NoWrite,
        input  PCSrc,
        input  RegWrite,
        input  MemWrite,
        input  CondEx,
        input  Flags
    );

    // Conditional-execution stage side.
    modport slave (
        input  en,
        input  Cond,
        input  ALUFlags,
        input  FlagW,
        input  PCS,
        input  RegW,
        input  MemW,
        input  NoWrite,
        output PCSrc,
        output RegWrite,
        output MemWrite,
        output CondEx,
        output Flags
    );

    // Passive observer.
    modport monitor (
        input en,
        input Cond,
        input ALUFlags,
        input FlagW,
        input PCS,
        input RegW,
        input MemW,
        input NoWrite,
        input PCSrc,
        input RegWrite,
        input MemWrite,
        input CondEx,
        input Flags
    );

endinterface

// File: rtl/cond_flag_unit.sv
// Conditional-execution stage sitting right after the ALU. It owns the
// architectural NZCV register, decides whether the current instruction's
// condition holds against the flags left by earlier instructions, and
// suppresses PC/register/memory writes of instructions that fail their
// condition, are stalled, or are caught by reset.
module cond_flag_unit #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    cond_flag_unit_if.slave  bus
);

    // Architectural condition codes, named after their assembler mnemonics.
    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } condCode_e;

    // Registered NZCV, ordered {N,Z,C,V}.
    logic [3:0] r_flags;

    // Individual flag bits of the registered value.
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    // Shared sub-terms of the condition table.
    logic       w_signedGe;
    logic       w_unsignedHi;

    // Decoded condition and its outcome.
    condCode_e  w_cond;
    logic       w_condEx;

    // Instruction is allowed to have architectural effect this cycle.
    logic       w_commit;

    // Per-group flag write enables.
    logic       w_writeNZ;
    logic       w_writeCV;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // N==V means "signed greater or equal" after a subtract; C&!Z means
    // "unsigned higher". Several conditions are built from these.
    assign w_signedGe   = (w_n == w_v);
    assign w_unsignedHi = w_c & ~w_z;

    assign w_cond = condCode_e'(bus.Cond);

    // Evaluate the condition field against the registered flags only, so an
    // instruction never observes the flags it is itself producing.
    always_comb begin
        w_condEx = 1'b0;
        case (w_cond)
            COND_EQ: w_condEx = w_z;
            COND_NE: w_condEx = ~w_z;
            COND_CS: w_condEx = w_c;
            COND_CC: w_condEx = ~w_c;
            COND_MI: w_condEx = w_n;
            COND_PL: w_condEx = ~w_n;
            COND_VS: w_condEx = w_v;
            COND_VC: w_condEx = ~w_v;
            COND_HI: w_condEx = w_unsignedHi;
            COND_LS: w_condEx = ~w_unsignedHi;
            COND_GE: w_condEx = w_signedGe;
            COND_LT: w_condEx = ~w_signedGe;
            COND_GT: w_condEx = ~w_z & w_signedGe;
            COND_LE: w_condEx = w_z | ~w_signedGe;
            COND_AL: w_condEx = 1'b1;
            COND_NV: w_condEx = 1'b1;
            default: w_condEx = 1'b1;
        endcase
    end

    // A valid, unstalled instruction whose condition passed and which is not
    // being squashed by reset is the only thing allowed to change state.
    assign w_commit = bus.en & w_condEx & ~rst;

    // Gate the decoder strobes. Compare-type ops still run through the ALU
    // and may set flags, but must not write a destination register.
    always_comb begin
        bus.PCSrc    = 1'b0;
        bus.RegWrite = 1'b0;
        bus.MemWrite = 1'b0;
        if (w_commit) begin
            bus.PCSrc    = bus.PCS;
            bus.RegWrite = bus.RegW & ~bus.NoWrite;
            bus.MemWrite = bus.MemW;
        end
    end

    // The two flag groups are written independently: logical ops request
    // only N,Z and must leave the carry/overflow from an earlier op intact.
    assign w_writeNZ = w_commit & bus.FlagW[1];
    assign w_writeCV = w_commit & bus.FlagW[0];

    // Flag register. Reset wins over any pending update in the same cycle,
    // so neither group is partially written when reset arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= FLAG_RESET;
        end else begin
            if (w_writeNZ) begin
                r_flags[3:2] <= bus.ALUFlags[3:2];
            end
            if (w_writeCV) begin
                r_flags[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    assign bus.CondEx = w_condEx;
    assign bus.Flags  = r_flags;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: a driver issues one instruction per
// cycle, predicts the stage's response from an architectural model of the
// NZCV flags and pushes it into a queue; an independent monitor pops and
// compares on the falling edge.
module tb_cond_flag_unit;

    localparam logic [3:0] FLAG_RESET = 4'b0000;

    typedef struct {
        int         tag;
        bit         condEx;
        bit         pcSrc;
        bit         regWrite;
        bit         memWrite;
        logic [3:0] flags;
    } expect_t;

    logic clk;
    logic rst;

    cond_flag_unit_if bus ();

    cond_flag_unit #(
        .FLAG_RESET (FLAG_RESET)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    expect_t    scoreQ[$];
    logic [3:0] modelFlags;
    int         tagCount  = 0;
    int         testsRun  = 0;
    int         testsFail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural meaning of a condition: pairs of codes share a base
    // predicate and the odd member of each pair is its negation.
    function automatic bit condModel(input logic [3:0] c, input logic [3:0] f);
        bit n;
        bit z;
        bit cy;
        bit v;
        bit base;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        if (c >= 4'hE) return 1'b1;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    // Compare one observed value against its prediction.
    task automatic checkOutput(input string name, input int tag,
                               input logic [3:0] actual, input logic [3:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s (item %0d): got %b, expected %b", name, tag, actual, expected);
        end
    endtask

    // Drive one instruction for the coming cycle, predict the response and
    // advance the model flags to what they should be after the next edge.
    task automatic applyStimulus(input bit r, input bit e, input logic [3:0] cond,
                                 input logic [3:0] alu, input logic [1:0] fw,
                                 input bit pcs, input bit regW, input bit memW,
                                 input bit noWr);
        expect_t exp;
        bit      pass;
        @(posedge clk);
        #1;
        rst          = r;
        bus.en       = e;
        bus.Cond     = cond;
        bus.ALUFlags = alu;
        bus.FlagW    = fw;
        bus.PCS      = pcs;
        bus.RegW     = regW;
        bus.MemW     = memW;
        bus.NoWrite  = noWr;

        pass         = condModel(cond, modelFlags);
        exp.tag      = tagCount++;
        exp.condEx   = pass;
        exp.pcSrc    = !r && e && pass && pcs;
        exp.regWrite = !r && e && pass && regW && !noWr;
        exp.memWrite = !r && e && pass && memW;
        exp.flags    = modelFlags;
        scoreQ.push_back(exp);

        if (r) begin
            modelFlags = FLAG_RESET;
        end else if (e && pass) begin
            if (fw[1]) modelFlags[3:2] = alu[3:2];
            if (fw[0]) modelFlags[1:0] = alu[1:0];
        end
    endtask

    // Independent check of the register against a hand-derived value in the
    // current cycle.
    task automatic expectFlags(input string name, input logic [3:0] value);
        @(negedge clk);
        checkOutput(name, -1, bus.Flags, value);
    endtask

    // Monitor: the stage presents a response every cycle an item is pending.
    always @(negedge clk) begin
        if (scoreQ.size() > 0) begin
            expect_t exp;
            exp = scoreQ.pop_front();
            checkOutput("CondEx",   exp.tag, {3'b000, bus.CondEx},   {3'b000, exp.condEx});
            checkOutput("PCSrc",    exp.tag, {3'b000, bus.PCSrc},    {3'b000, exp.pcSrc});
            checkOutput("RegWrite", exp.tag, {3'b000, bus.RegWrite}, {3'b000, exp.regWrite});
            checkOutput("MemWrite", exp.tag, {3'b000, bus.MemWrite}, {3'b000, exp.memWrite});
            checkOutput("Flags",    exp.tag, bus.Flags,              exp.flags);
        end
    end

    initial begin
        int drain;
        rst          = 1'b1;
        bus.en       = 1'b1;
        bus.Cond     = 4'hE;
        bus.ALUFlags = 4'b1111;
        bus.FlagW    = 2'b11;
        bus.PCS      = 1'b1;
        bus.RegW     = 1'b1;
        bus.MemW     = 1'b1;
        bus.NoWrite  = 1'b0;
        modelFlags   = FLAG_RESET;
        @(posedge clk);

        // Reset held with a flag-setting instruction present.
        applyStimulus(1, 1, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
        applyStimulus(1, 1, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
        expectFlags("ResetFlags", 4'b0000);
        applyStimulus(0, 1, 4'hE, 4'b0000, 2'b00, 0, 1, 0, 0);

        // SUBS equal, then BEQ taken and BNE not taken.
        applyStimulus(0, 1, 4'hE, 4'b0110, 2'b11, 0, 1, 0, 1);
        applyStimulus(0, 1, 4'h0, 4'b0000, 2'b00, 1, 0, 0, 0);
        expectFlags("SubsFlags", 4'b0110);
        applyStimulus(0, 1, 4'h1, 4'b0000, 2'b00, 1, 0, 0, 0);

        // Logical op updates N,Z only.
        applyStimulus(0, 1, 4'hE, 4'b0011, 2'b11, 0, 0, 0, 0);
        applyStimulus(0, 1, 4'hE, 4'b1000, 2'b10, 0, 1, 0, 0);
        applyStimulus(0, 1, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0);
        expectFlags("PartialFlags", 4'b1011);

        // Failed condition on a flag-setting store/write.
        applyStimulus(0, 1, 4'hE, 4'b0000, 2'b11, 0, 0, 0, 0);
        applyStimulus(0, 1, 4'h0, 4'b0100, 2'b11, 0, 1, 1, 0);
        applyStimulus(0, 1, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0);
        expectFlags("FailedCondFlags", 4'b0000);

        // Signed compares with N=1,V=0 then N=1,V=1,Z=0.
        applyStimulus(0, 1, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0);
        applyStimulus(0, 1, 4'hA, 4'b0000, 2'b00, 0, 1, 0, 0);
        applyStimulus(0, 1, 4'hB, 4'b0000, 2'b00, 0, 1, 0, 0);
        applyStimulus(0, 1, 4'hD, 4'b0000, 2'b00, 0, 1, 0, 0);
        applyStimulus(0, 1, 4'hC, 4'b0000, 2'b00, 0, 1, 0, 0);
        applyStimulus(0, 1, 4'hE, 4'b1001, 2'b11, 0, 0, 0, 0);
        applyStimulus(0, 1, 4'hA, 4'b0000, 2'b00, 0, 1, 0, 0);
        applyStimulus(0, 1, 4'hC, 4'b0000, 2'b00, 0, 1, 0, 0);
        applyStimulus(0, 1, 4'hE, 4'b0000, 2'b00, 0, 1, 0, 1);

        // Stall, then the same instruction released.
        applyStimulus(0, 0, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
        applyStimulus(0, 1, 4'hE, 4'b0101, 2'b11, 1, 1, 1, 0);
        expectFlags("StallHeldFlags", 4'b1001);
        applyStimulus(0, 1, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0);
        expectFlags("StallReleasedFlags", 4'b0101);

        // Randomized traffic with occasional stalls and resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 31) == 0),
                          ($urandom_range(0, 7) != 0),
                          4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0));
        end

        drain = 0;
        while (scoreQ.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        testsRun++;
        if (scoreQ.size() != 0) begin
            testsFail++;
            $display("[TB] FAIL drain: %0d items pending, expected 0", scoreQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
